// File: rtl/fe_pkg.sv
// fe_pkg: shared front-end types for the RV32I decode stage.
// Format enum, base opcodes and the decoded-entry record.
package fe_pkg;

   localparam int XLEN_MAX = 64;

   typedef enum logic [2:0] {
      FMT_R    = 3'd0,
      FMT_I    = 3'd1,
      FMT_S    = 3'd2,
      FMT_B    = 3'd3,
      FMT_U    = 3'd4,
      FMT_J    = 3'd5,
      FMT_NONE = 3'd6
   } RV32I_FORMAT_t;

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_OPIMM  = 7'b0010011;
   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_FENCE  = 7'b0001111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   typedef struct packed {
      RV32I_FORMAT_t       format;
      logic [6:0]          opcode;
      logic [2:0]          funct3;
      logic [6:0]          funct7;
      logic [4:0]          rs1;
      logic [4:0]          rs2;
      logic [4:0]          rd;
      logic [XLEN_MAX-1:0] imm;
      logic                illegal;
   } RV32I_DECODED_t;

   function automatic RV32I_FORMAT_t opcode_format(input logic [6:0] op);
      RV32I_FORMAT_t f;
      case (op)
         OP_OP:                         f = FMT_R;
         OP_OPIMM, OP_LOAD, OP_JALR,
         OP_SYSTEM, OP_FENCE:           f = FMT_I;
         OP_STORE:                      f = FMT_S;
         OP_BRANCH:                     f = FMT_B;
         OP_LUI, OP_AUIPC:              f = FMT_U;
         OP_JAL:                        f = FMT_J;
         default:                       f = FMT_NONE;
      endcase
      return f;
   endfunction

endpackage

// File: rtl/rv32i_imm_gen.sv
// rv32i_imm_gen: combinational immediate generator, sign bit instr[31].
// Shared with the branch unit.
module rv32i_imm_gen
   import fe_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]     instr,
   input  RV32I_FORMAT_t   format,
   output logic [XLEN-1:0] imm
);

   logic [31:0] i32;
   logic        unused_op;

   assign unused_op = ^instr[6:0];

   always_comb begin
      i32 = '0;
      case (format)
         FMT_I: i32 = {{20{instr[31]}}, instr[31:20]};
         FMT_S: i32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         FMT_B: i32 = {{19{instr[31]}}, instr[31], instr[7],
                       instr[30:25], instr[11:8], 1'b0};
         FMT_U: i32 = {instr[31:12], 12'b0};
         FMT_J: i32 = {{11{instr[31]}}, instr[31], instr[19:12],
                       instr[20], instr[30:21], 1'b0};
         default: i32 = '0;
      endcase
   end

   assign imm = XLEN'($signed(i32));

endmodule

// File: rtl/rv32i_decode_stage.sv
// rv32i_decode_stage: registered RV32I decoder feeding a small FIFO
// of decoded entries with valid/ready on both sides and a flush.
module rv32i_decode_stage
   import fe_pkg::*;
#(
   parameter int XLEN          = 32,
   parameter int DEPTH         = 2,
   parameter int CHECK_ILLEGAL = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [XLEN-1:0] in_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [2:0]      out_format,
   output logic [6:0]      out_opcode,
   output logic [2:0]      out_funct3,
   output logic [6:0]      out_funct7,
   output logic [4:0]      out_rs1,
   output logic [4:0]      out_rs2,
   output logic [4:0]      out_rd,
   output logic [XLEN-1:0] out_imm,
   output logic            out_illegal
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [6:0]      op;
   logic [2:0]      f3;
   logic [6:0]      f7;
   RV32I_FORMAT_t   fmt;
   logic            is_shift;
   logic            bad;
   logic [XLEN-1:0] imm;
   RV32I_DECODED_t  dec;

   assign op       = in_instr[6:0];
   assign f3       = in_instr[14:12];
   assign f7       = in_instr[31:25];
   assign fmt      = opcode_format(op);
   assign is_shift = (op == OP_OPIMM) && (f3 == 3'b001 || f3 == 3'b101);

   rv32i_imm_gen #(.XLEN(XLEN)) u_imm (
      .instr  (in_instr),
      .format (fmt),
      .imm    (imm)
   );

   always_comb begin
      bad = (in_instr[1:0] != 2'b11) || (fmt == FMT_NONE);
      unique case (1'b1)
         op == OP_OP:
            bad = bad || !(f7 == 7'h00 ||
                  (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101)));
         is_shift:
            bad = bad || ((f3 == 3'b001) ? (f7 != 7'h00)
                  : !(f7 == 7'h00 || f7 == 7'h20));
         op == OP_BRANCH:
            bad = bad || f3 == 3'b010 || f3 == 3'b011;
         op == OP_LOAD:
            bad = bad || f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111;
         op == OP_STORE:
            bad = bad || f3 > 3'b010;
         op == OP_JALR:
            bad = bad || f3 != 3'b000;
         default: ;
      endcase
   end

   always_comb begin
      dec         = '0;
      dec.format  = fmt;
      dec.opcode  = op;
      dec.illegal = (CHECK_ILLEGAL != 0) && bad;
      dec.imm     = XLEN_MAX'($signed(imm));
      if (fmt inside {FMT_R, FMT_I, FMT_S, FMT_B}) begin
         dec.funct3 = f3;
         dec.rs1    = in_instr[19:15];
      end
      if (fmt inside {FMT_R, FMT_S, FMT_B})
         dec.rs2 = in_instr[24:20];
      if (fmt inside {FMT_R, FMT_I, FMT_U, FMT_J})
         dec.rd = in_instr[11:7];
      if (fmt == FMT_R || is_shift)
         dec.funct7 = f7;
   end

   RV32I_DECODED_t  mem [DEPTH];
   logic [XLEN-1:0] pcs [DEPTH];
   logic [PW-1:0]   wptr;
   logic [PW-1:0]   rptr;
   logic [CW-1:0]   count;
   logic            push;
   logic            pop;

   function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign in_ready  = count < CW'(DEPTH);
   assign out_valid = count != '0;
   assign push      = in_valid && in_ready && !flush;
   assign pop       = out_valid && out_ready;

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push)
            wptr <= bump(wptr);
         if (pop)
            rptr <= bump(rptr);
         if (push && !pop)
            count <= count + CW'(1);
         else if (pop && !push)
            count <= count - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wptr] <= dec;
         pcs[wptr] <= in_pc;
      end
   end

   // Gate the head so an empty stage shows zeros, never stale entries.
   RV32I_DECODED_t head;
   logic           unused_imm;

   assign head       = out_valid ? mem[rptr] : '0;
   assign out_pc     = out_valid ? pcs[rptr] : '0;
   assign out_format = head.format;
   assign out_opcode = head.opcode;
   assign out_funct3 = head.funct3;
   assign out_funct7 = head.funct7;
   assign out_rs1    = head.rs1;
   assign out_rs2    = head.rs2;
   assign out_rd     = head.rd;
   assign out_imm    = head.imm[XLEN-1:0];
   assign out_illegal = head.illegal;
   assign unused_imm = ^head.imm;

endmodule

// File: tb/tb_rv32i_decode_stage.sv
// tb_rv32i_decode_stage: vector table, directed flow-control sequences
// and random traffic against a queue-based model on two configurations.
module tb_rv32i_decode_stage;
   import fe_pkg::*;

   typedef struct packed {
      logic        valid;
      logic [63:0] pc;
      logic [2:0]  fmt;
      logic [6:0]  op;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [63:0] imm;
      logic        ill;
   } obs_t;

   typedef struct {
      logic [31:0] instr;
      logic [2:0]  fmt;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [63:0] imm;
      logic        ill;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic [31:0] in_instr = '0;
   logic [63:0] pc64 = '0;

   always #5 clk = ~clk;

   logic        a_in_ready, a_out_valid, a_ill;
   logic [31:0] a_pc, a_imm;
   logic [2:0]  a_fmt, a_f3;
   logic [6:0]  a_op, a_f7;
   logic [4:0]  a_rs1, a_rs2, a_rd;

   logic        b_in_ready, b_out_valid, b_ill;
   logic [63:0] b_pc, b_imm;
   logic [2:0]  b_fmt, b_f3;
   logic [6:0]  b_op, b_f7;
   logic [4:0]  b_rs1, b_rs2, b_rd;

   rv32i_decode_stage #(.XLEN(32), .DEPTH(2), .CHECK_ILLEGAL(1)) dut_a (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(a_in_ready),
      .in_instr(in_instr), .in_pc(pc64[31:0]),
      .out_valid(a_out_valid), .out_ready(out_ready),
      .out_pc(a_pc), .out_format(a_fmt), .out_opcode(a_op),
      .out_funct3(a_f3), .out_funct7(a_f7), .out_rs1(a_rs1),
      .out_rs2(a_rs2), .out_rd(a_rd), .out_imm(a_imm),
      .out_illegal(a_ill)
   );

   rv32i_decode_stage #(.XLEN(64), .DEPTH(3), .CHECK_ILLEGAL(1)) dut_b (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(b_in_ready),
      .in_instr(in_instr), .in_pc(pc64),
      .out_valid(b_out_valid), .out_ready(out_ready),
      .out_pc(b_pc), .out_format(b_fmt), .out_opcode(b_op),
      .out_funct3(b_f3), .out_funct7(b_f7), .out_rs1(b_rs1),
      .out_rs2(b_rs2), .out_rd(b_rd), .out_imm(b_imm),
      .out_illegal(b_ill)
   );

   obs_t oa, ob;

   always_comb begin
      oa = '{valid: a_out_valid, pc: {32'b0, a_pc}, fmt: a_fmt, op: a_op,
             f3: a_f3, f7: a_f7, rs1: a_rs1, rs2: a_rs2, rd: a_rd,
             imm: {32'b0, a_imm}, ill: a_ill};
      ob = '{valid: b_out_valid, pc: b_pc, fmt: b_fmt, op: b_op,
             f3: b_f3, f7: b_f7, rs1: b_rs1, rs2: b_rs2, rd: b_rd,
             imm: b_imm, ill: b_ill};
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", name, act, exp);
      end
   endtask

   task automatic chk_obs(string t, obs_t act, obs_t exp);
      chk({t, ".valid"}, 64'(act.valid), 64'(exp.valid));
      chk({t, ".pc"}, act.pc, exp.pc);
      chk({t, ".format"}, 64'(act.fmt), 64'(exp.fmt));
      chk({t, ".opcode"}, 64'(act.op), 64'(exp.op));
      chk({t, ".funct3"}, 64'(act.f3), 64'(exp.f3));
      chk({t, ".funct7"}, 64'(act.f7), 64'(exp.f7));
      chk({t, ".rs1"}, 64'(act.rs1), 64'(exp.rs1));
      chk({t, ".rs2"}, 64'(act.rs2), 64'(exp.rs2));
      chk({t, ".rd"}, 64'(act.rd), 64'(exp.rd));
      chk({t, ".imm"}, act.imm, exp.imm);
      chk({t, ".illegal"}, 64'(act.ill), 64'(exp.ill));
   endtask

   // Reference decode built from the instruction-set rules directly.
   function automatic obs_t model(logic [31:0] i, logic [63:0] pc, int xlen);
      obs_t   e;
      longint s;
      longint imm;
      logic   f_r, f_i, f_s, f_b, f_u, f_j;
      int     f3, f7;
      e   = '0;
      s   = longint'($signed(i));
      f3  = int'(i[14:12]);
      f7  = int'(i[31:25]);
      f_r = i[6:0] == 7'b0110011;
      f_i = i[6:0] inside {7'b0010011, 7'b0000011, 7'b1100111,
                           7'b1110011, 7'b0001111};
      f_s = i[6:0] == 7'b0100011;
      f_b = i[6:0] == 7'b1100011;
      f_u = i[6:0] inside {7'b0110111, 7'b0010111};
      f_j = i[6:0] == 7'b1101111;
      e.valid = 1'b1;
      e.op    = i[6:0];
      e.pc    = (xlen == 32) ? (pc & 64'hFFFF_FFFF) : pc;
      imm     = 0;
      e.fmt   = f_r ? 3'(FMT_R) : f_i ? 3'(FMT_I) : f_s ? 3'(FMT_S) :
                f_b ? 3'(FMT_B) : f_u ? 3'(FMT_U) : f_j ? 3'(FMT_J) :
                3'(FMT_NONE);
      if (f_r || f_i || f_s || f_b) begin
         e.f3  = i[14:12];
         e.rs1 = i[19:15];
      end
      if (f_r || f_s || f_b) e.rs2 = i[24:20];
      if (f_r || f_i || f_u || f_j) e.rd = i[11:7];
      if (f_r || (i[6:0] == 7'b0010011 && (f3 == 1 || f3 == 5)))
         e.f7 = i[31:25];
      if (f_i) imm = s >>> 20;
      if (f_s) imm = ((s >>> 25) << 5) + longint'(i[11:7]);
      if (f_b) imm = ((s >>> 31) << 12) + (longint'(i[7]) << 11)
                   + (longint'(i[30:25]) << 5) + (longint'(i[11:8]) << 1);
      if (f_u) imm = s & -64'sd4096;
      if (f_j) imm = ((s >>> 31) << 20) + (longint'(i[19:12]) << 12)
                   + (longint'(i[20]) << 11) + (longint'(i[30:21]) << 1);
      e.imm = (xlen == 32) ? (imm & 64'hFFFF_FFFF) : imm;
      e.ill = (i[1:0] != 2'b11) || !(f_r || f_i || f_s || f_b || f_u || f_j);
      if (f_r && !(f7 == 0 || (f7 == 32 && (f3 == 0 || f3 == 5)))) e.ill = 1'b1;
      if (i[6:0] == 7'b0010011 && f3 == 1 && f7 != 0) e.ill = 1'b1;
      if (i[6:0] == 7'b0010011 && f3 == 5 && f7 != 0 && f7 != 32) e.ill = 1'b1;
      if (f_b && (f3 == 2 || f3 == 3)) e.ill = 1'b1;
      if (i[6:0] == 7'b0000011 && (f3 == 3 || f3 == 6 || f3 == 7)) e.ill = 1'b1;
      if (f_s && f3 > 2) e.ill = 1'b1;
      if (i[6:0] == 7'b1100111 && f3 != 0) e.ill = 1'b1;
      return e;
   endfunction

   function automatic obs_t vexp(vec_t v, logic [63:0] pc, int xlen);
      obs_t e;
      e = '{valid: 1'b1, pc: pc, fmt: v.fmt, op: v.instr[6:0], f3: v.f3,
            f7: v.f7, rs1: v.rs1, rs2: v.rs2, rd: v.rd, imm: v.imm,
            ill: v.ill};
      if (xlen == 32) begin
         e.pc  = pc & 64'hFFFF_FFFF;
         e.imm = v.imm & 64'hFFFF_FFFF;
      end
      return e;
   endfunction

   function automatic vec_t mk(logic [31:0] ins, RV32I_FORMAT_t f,
                               logic [4:0] rs1, logic [4:0] rs2,
                               logic [4:0] rd, logic [2:0] f3,
                               logic [6:0] f7, logic [63:0] imm,
                               logic ill);
      vec_t v;
      v = '{instr: ins, fmt: f, rs1: rs1, rs2: rs2, rd: rd, f3: f3,
            f7: f7, imm: imm, ill: ill};
      return v;
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [31:0] r;
      r = $urandom;
      if ($urandom_range(0, 7) != 0) begin
         case ($urandom_range(0, 10))
            0: r[6:0] = 7'b0110111;
            1: r[6:0] = 7'b0010111;
            2: r[6:0] = 7'b1101111;
            3: r[6:0] = 7'b1100111;
            4: r[6:0] = 7'b1100011;
            5: r[6:0] = 7'b0000011;
            6: r[6:0] = 7'b0100011;
            7: r[6:0] = 7'b0010011;
            8: r[6:0] = 7'b0110011;
            9: r[6:0] = 7'b0001111;
            default: r[6:0] = 7'b1110011;
         endcase
      end
      if ($urandom_range(0, 1) == 1)
         r[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
      return r;
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      flush = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      repeat (2) cyc();
      rst = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1, "watchdog");
   end

   vec_t          tab[$];
   obs_t          qa[$];
   obs_t          qb[$];
   logic [63:0]   got[$];
   int            idx;
   logic          pa, pb, ppa, ppb;
   obs_t          zero;

   initial begin
      zero = '0;
      do_reset();
      @(negedge clk);
      chk_obs("reset.a", oa, zero);
      chk_obs("reset.b", ob, zero);
      chk("reset.a.in_ready", 64'(a_in_ready), 64'd1);
      chk("reset.b.in_ready", 64'(b_in_ready), 64'd1);

      tab.push_back(mk(32'hFFF10093, FMT_I, 5'd2, 5'd0, 5'd1, 3'd0, 7'h00,
                       64'hFFFF_FFFF_FFFF_FFFF, 1'b0));
      tab.push_back(mk(32'h00532423, FMT_S, 5'd6, 5'd5, 5'd0, 3'd2, 7'h00,
                       64'd8, 1'b0));
      tab.push_back(mk(32'hFE000EE3, FMT_B, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00,
                       64'hFFFF_FFFF_FFFF_FFFC, 1'b0));
      tab.push_back(mk(32'h123451B7, FMT_U, 5'd0, 5'd0, 5'd3, 3'd0, 7'h00,
                       64'h1234_5000, 1'b0));
      tab.push_back(mk(32'h001000EF, FMT_J, 5'd0, 5'd0, 5'd1, 3'd0, 7'h00,
                       64'h800, 1'b0));
      tab.push_back(mk(32'h800001B7, FMT_U, 5'd0, 5'd0, 5'd3, 3'd0, 7'h00,
                       64'hFFFF_FFFF_8000_0000, 1'b0));
      tab.push_back(mk(32'h40002033, FMT_R, 5'd0, 5'd0, 5'd0, 3'd2, 7'h20,
                       64'd0, 1'b1));
      tab.push_back(mk(32'h00000010, FMT_NONE, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00,
                       64'd0, 1'b1));
      tab.push_back(mk(32'h40005033, FMT_R, 5'd0, 5'd0, 5'd0, 3'd5, 7'h20,
                       64'd0, 1'b0));
      tab.push_back(mk(32'h02009093, FMT_I, 5'd1, 5'd0, 5'd1, 3'd1, 7'h01,
                       64'd32, 1'b1));
      tab.push_back(mk(32'h4041D113, FMT_I, 5'd3, 5'd0, 5'd2, 3'd5, 7'h20,
                       64'h404, 1'b0));

      // Back-to-back stream, one delivered entry per cycle.
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_instr  = tab[0].instr;
      pc64      = 64'h0000_0001_0000_1000;
      for (int i = 0; i < tab.size(); i++) begin
         cyc();
         in_valid = (i + 1 < tab.size());
         if (i + 1 < tab.size()) begin
            in_instr = tab[i + 1].instr;
            pc64     = 64'h0000_0001_0000_1000 + 64'(4 * (i + 1));
         end
         @(negedge clk);
         chk_obs($sformatf("tab%0d.a", i), oa,
                 vexp(tab[i], 64'h0000_0001_0000_1000 + 64'(4 * i), 32));
         chk_obs($sformatf("tab%0d.b", i), ob,
                 vexp(tab[i], 64'h0000_0001_0000_1000 + 64'(4 * i), 64));
      end
      in_valid = 1'b0;
      cyc();

      // Backpressure: three offers into a two-entry buffer.
      do_reset();
      idx = 0;
      got.delete();
      for (int c = 0; c < 12; c++) begin
         cyc();
         out_ready = (c >= 3);
         in_valid  = (idx < 3);
         in_instr  = 32'h00100093;
         pc64      = 64'h200 + 64'(4 * idx);
         @(negedge clk);
         if (c == 2) chk("bp.in_ready_full", 64'(a_in_ready), 64'd0);
         if (c == 3) chk("bp.in_ready_hold", 64'(a_in_ready), 64'd0);
         if (a_out_valid && out_ready) got.push_back({32'b0, a_pc});
         if (in_valid && a_in_ready) idx++;
      end
      in_valid = 1'b0;
      chk("bp.accepted", 64'(idx), 64'd3);
      chk("bp.delivered", 64'(got.size()), 64'd3);
      for (int k = 0; k < 3; k++)
         if (k < got.size())
            chk($sformatf("bp.order%0d", k), got[k], 64'h200 + 64'(4 * k));

      // Flush with two entries held and an offered input.
      do_reset();
      out_ready = 1'b0;
      for (int k = 0; k < 2; k++) begin
         in_valid = 1'b1;
         in_instr = 32'h00532423;
         pc64     = 64'h300 + 64'(4 * k);
         cyc();
      end
      flush    = 1'b1;
      in_instr = 32'hFFF10093;
      pc64     = 64'h400;
      @(negedge clk);
      chk("fl.pre.a.out_valid", 64'(a_out_valid), 64'd1);
      cyc();
      flush    = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      chk_obs("fl.a", oa, zero);
      chk_obs("fl.b", ob, zero);
      chk("fl.a.in_ready", 64'(a_in_ready), 64'd1);
      cyc();
      in_valid = 1'b1;
      in_instr = 32'h123451B7;
      pc64     = 64'h500;
      cyc();
      in_valid = 1'b0;
      @(negedge clk);
      chk_obs("fl.next.a", oa, model(32'h123451B7, 64'h500, 32));
      chk_obs("fl.next.b", ob, model(32'h123451B7, 64'h500, 64));

      // Random traffic on both configurations against queue models.
      do_reset();
      qa.delete();
      qb.delete();
      for (int c = 0; c < 4000; c++) begin
         cyc();
         rst       = ($urandom_range(0, 299) == 0);
         flush     = ($urandom_range(0, 24) == 0);
         in_valid  = ($urandom_range(0, 9) < 7);
         out_ready = ($urandom_range(0, 9) < 6);
         in_instr  = rand_instr();
         pc64      = {$urandom, $urandom};
         @(negedge clk);
         chk("rnd.a.in_ready", 64'(a_in_ready), 64'(qa.size() < 2));
         chk("rnd.b.in_ready", 64'(b_in_ready), 64'(qb.size() < 3));
         chk_obs("rnd.a", oa, (qa.size() > 0) ? qa[0] : zero);
         chk_obs("rnd.b", ob, (qb.size() > 0) ? qb[0] : zero);
         pa  = in_valid && (qa.size() < 2);
         pb  = in_valid && (qb.size() < 3);
         ppa = out_ready && (qa.size() > 0);
         ppb = out_ready && (qb.size() > 0);
         if (rst || flush) begin
            qa.delete();
            qb.delete();
         end else begin
            if (ppa) void'(qa.pop_front());
            if (ppb) void'(qb.pop_front());
            if (pa) qa.push_back(model(in_instr, pc64, 32));
            if (pb) qb.push_back(model(in_instr, pc64, 64));
         end
      end
      rst = 1'b0;
      flush = 1'b0;
      in_valid = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
